ddr3_pg_arb: RTL and testbench

- Round-robin arbiter that shares the single DDR3 page-transfer port (req/optype/addr/ack, 4-phase) among N_REQ page requesters, e.g. hit buffer controller, readout drain, test writer.
- Sits between the requesters and the DDR3 page mover.
- Drives grant_idx so the page-DPRAM read-data mux follows the active requester.
- One transfer at a time; the grant is locked until the full 4-phase handshake completes on both sides.

---
 rtl/ddr3_pg_arb.sv | 151 +++++++++++++++
 tb/tb_ddr3_pg_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pg_arb.sv
// rtl/ddr3_pg_arb.sv - round-robin arbiter sharing the DDR3 page-transfer port among N_REQ requesters
// Optional ack watchdog with sticky err: define DDR3_ARB_TIMEOUT_EN.
module ddr3_pg_arb #(
    parameter int N_REQ          = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      optype,
    input  logic [28*N_REQ-1:0]   addr,
    output logic [N_REQ-1:0]      ack,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic                  ddr_req,
    output logic                  ddr_optype,
    output logic [27:0]           ddr_addr,
    input  logic                  ddr_ack,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK_HI, S_WAIT_LO} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   last_grant, last_grant_d, grant_idx_d, winner;
    logic [N_REQ-1:0]   ack_d;
    logic               grant_valid_d, ddr_req_d, ddr_optype_d, err_d;
    logic [27:0]        ddr_addr_d, win_addr;
    logic               win_op, req_granted, timeout;
    int                 off, best_off;

    // Rotating priority: smallest distance after last_grant wins.
    always_comb begin
        best_off = N_REQ;
        winner   = '0;
        win_addr = '0;
        win_op   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            off = (i + N_REQ - 1 - int'(last_grant)) % N_REQ;
            if (req[i] && off < best_off) begin
                best_off = off;
                winner   = IDX_W'(i);
                win_addr = addr[28*i +: 28];
                win_op   = optype[i];
            end
        end
    end

    always_comb begin
        req_granted = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) req_granted = req[i];
        end
    end

`ifdef DDR3_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT_ACK_HI) wd_cnt <= '0;
        else                               wd_cnt <= wd_cnt + 32'd1;
    end

    assign timeout = (state == S_WAIT_ACK_HI) && (wd_cnt == 32'(TIMEOUT_CYCLES));
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        grant_idx_d   = grant_idx;
        last_grant_d  = last_grant;
        ack_d         = ack;
        grant_valid_d = grant_valid;
        ddr_req_d     = ddr_req;
        ddr_optype_d  = ddr_optype;
        ddr_addr_d    = ddr_addr;
        err_d         = 1'b0;
        case (state)
            S_IDLE: begin
                // A stale ddr_ack from the previous transfer must not start a new one.
                if (|req && !ddr_ack) begin
                    state_d       = S_WAIT_ACK_HI;
                    grant_idx_d   = winner;
                    ddr_addr_d    = win_addr;
                    ddr_optype_d  = win_op;
                    grant_valid_d = 1'b1;
                    ddr_req_d     = 1'b1;
                end
            end
            S_WAIT_ACK_HI: begin
                if (ddr_ack) begin
                    ddr_req_d = 1'b0;
                    for (int i = 0; i < N_REQ; i++) ack_d[i] = (grant_idx == IDX_W'(i));
                    state_d   = S_WAIT_LO;
                end else if (timeout) begin
                    ddr_req_d     = 1'b0;
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_idx;
                    state_d       = S_IDLE;
                end
            end
            S_WAIT_LO: begin
                if (!req_granted && !ddr_ack) begin
                    ack_d         = '0;
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_idx;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DDR3_ARB_TIMEOUT_EN
        err_d = err;
        if (err_clr) err_d = 1'b0;
        if (timeout && !ddr_ack) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= IDX_W'(N_REQ-1);
            grant_idx   <= '0;
            ack         <= '0;
            grant_valid <= 1'b0;
            ddr_req     <= 1'b0;
            ddr_optype  <= 1'b0;
            ddr_addr    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            grant_idx   <= grant_idx_d;
            ack         <= ack_d;
            grant_valid <= grant_valid_d;
            ddr_req     <= ddr_req_d;
            ddr_optype  <= ddr_optype_d;
            ddr_addr    <= ddr_addr_d;
            err         <= err_d;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ddr3_pg_arb.sv
// tb/tb_ddr3_pg_arb.sv - self-checking bench for ddr3_pg_arb
// Covers the DDR3_ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_ddr3_pg_arb;
    localparam int N = 4;
    localparam int W = 2;
    localparam logic [27:0] A0 = 28'h0000100;
    localparam logic [27:0] A1 = 28'h0003000;
    localparam logic [27:0] A2 = 28'hABC0000;
    localparam logic [27:0] A3 = 28'hFFFFFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     optype = '0;
    logic [28*N-1:0]  addr = '0;
    logic             ddr_ack = 1'b0;
    logic             err_clr = 1'b0;
    logic [N-1:0]     ack;
    logic [W-1:0]     grant_idx;
    logic             grant_valid, ddr_req, ddr_optype, busy, err;
    logic [27:0]      ddr_addr;

    ddr3_pg_arb #(.N_REQ(N), .IDX_W(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .optype(optype), .addr(addr),
        .ack(ack), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .ddr_req(ddr_req), .ddr_optype(ddr_optype), .ddr_addr(ddr_addr),
        .ddr_ack(ddr_ack), .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input logic dr, input logic [N-1:0] ak, input logic [W-1:0] gi,
                                       input logic gv, input logic bz, input logic op,
                                       input logic [27:0] ad, input logic er);
        return {25'd0, dr, ak, gi, gv, bz, op, ad, er};
    endfunction

    function automatic logic [63:0] pack_dut();
        return pk(ddr_req, ack, grant_idx, grant_valid, busy, ddr_optype, ddr_addr, err);
    endfunction

    typedef struct {
        logic         r;
        logic [N-1:0] rq;
        logic         da;
        logic         dr;
        logic [N-1:0] ak;
        logic [W-1:0] gi;
        logic         gv;
        logic [27:0]  ad;
        logic         op;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, input logic [N-1:0] rq, input logic da, input logic dr,
                     input logic [N-1:0] ak, input logic [W-1:0] gi, input logic gv,
                     input logic [27:0] ad, input logic op);
        vec_t t;
        t.r = r; t.rq = rq; t.da = da; t.dr = dr; t.ak = ak;
        t.gi = gi; t.gv = gv; t.ad = ad; t.op = op;
        tbl.push_back(t);
    endtask

    // Transaction-level reference: who owns the port, and whether the mover has acked.
    int          m_owner, m_last, m_gidx;
    bit          m_acked;
    logic [27:0] m_addr;
    logic        m_op;

    task automatic m_reset;
        m_owner = -1; m_last = N-1; m_gidx = 0; m_acked = 0; m_addr = '0; m_op = 1'b0;
    endtask

    task automatic m_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] op,
                          input logic [28*N-1:0] ad, input logic da);
        if (r) begin
            m_reset();
        end else if (m_owner < 0) begin
            if (rq != '0 && !da) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (rq[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_gidx  = m_owner;
                m_addr  = ad[28*m_owner +: 28];
                m_op    = op[m_owner];
                m_acked = 0;
            end
        end else if (!m_acked) begin
            if (da) m_acked = 1;
        end else if (!rq[m_owner] && !da) begin
            m_last  = m_owner;
            m_owner = -1;
            m_acked = 0;
        end
    endtask

    function automatic logic [N-1:0] m_ack();
        logic [N-1:0] a;
        a = '0;
        if (m_owner >= 0 && m_acked) a[m_owner] = 1'b1;
        return a;
    endfunction

    function automatic logic [63:0] m_pack();
        logic gv;
        gv = (m_owner >= 0);
        return pk(gv && !m_acked, m_ack(), W'(m_gidx), gv, gv, m_op, m_addr, 1'b0);
    endfunction

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        optype = 4'b1010;
        addr   = {A3, A2, A1, A0};

        // r  req      da    ddr_req ack     gi  gv  addr op
        v(1, 4'b0000, 0,    0, 4'b0000, 0,  0,  28'd0, 0);
        for (int i = 0; i < 5; i++)
            v(0, 4'b0010, 0, 1, 4'b0000, 1, 1, A1, 1);
        v(0, 4'b0010, 1,    0, 4'b0010, 1,  1,  A1, 1);
        v(0, 4'b0010, 1,    0, 4'b0010, 1,  1,  A1, 1);
        v(0, 4'b0000, 1,    0, 4'b0010, 1,  1,  A1, 1);
        v(0, 4'b0000, 0,    0, 4'b0000, 1,  0,  A1, 1);
        v(0, 4'b0100, 0,    1, 4'b0000, 2,  1,  A2, 0);
        v(0, 4'b0100, 1,    0, 4'b0100, 2,  1,  A2, 0);
        v(0, 4'b0000, 0,    0, 4'b0000, 2,  0,  A2, 0);
        v(0, 4'b1010, 0,    1, 4'b0000, 3,  1,  A3, 1);
        v(0, 4'b1010, 1,    0, 4'b1000, 3,  1,  A3, 1);
        v(0, 4'b0010, 0,    0, 4'b0000, 3,  0,  A3, 1);
        v(0, 4'b0010, 0,    1, 4'b0000, 1,  1,  A1, 1);
        v(0, 4'b0010, 1,    0, 4'b0010, 1,  1,  A1, 1);
        v(0, 4'b0000, 0,    0, 4'b0000, 1,  0,  A1, 1);
        v(0, 4'b0001, 1,    0, 4'b0000, 1,  0,  A1, 1);
        v(0, 4'b0001, 1,    0, 4'b0000, 1,  0,  A1, 1);
        v(0, 4'b0001, 0,    1, 4'b0000, 0,  1,  A0, 0);
        v(0, 4'b0001, 1,    0, 4'b0001, 0,  1,  A0, 0);
        v(0, 4'b0001, 0,    0, 4'b0001, 0,  1,  A0, 0);
        v(0, 4'b0000, 0,    0, 4'b0000, 0,  0,  A0, 0);
        v(0, 4'b0100, 0,    1, 4'b0000, 2,  1,  A2, 0);
        v(0, 4'b0100, 0,    1, 4'b0000, 2,  1,  A2, 0);
        v(0, 4'b0000, 0,    1, 4'b0000, 2,  1,  A2, 0);
        v(0, 4'b0000, 1,    0, 4'b0100, 2,  1,  A2, 0);
        v(0, 4'b0000, 0,    0, 4'b0000, 2,  0,  A2, 0);
        v(0, 4'b0001, 0,    1, 4'b0000, 0,  1,  A0, 0);
        v(0, 4'b0001, 1,    0, 4'b0001, 0,  1,  A0, 0);
        v(1, 4'b0001, 1,    0, 4'b0000, 0,  0,  28'd0, 0);
        v(0, 4'b1111, 0,    1, 4'b0000, 0,  1,  A0, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; req = tbl[i].rq; ddr_ack = tbl[i].da;
            tick();
            check($sformatf("vec%0d", i), pack_dut(),
                  pk(tbl[i].dr, tbl[i].ak, tbl[i].gi, tbl[i].gv, tbl[i].gv, tbl[i].op, tbl[i].ad, 1'b0));
        end

        // All four requesting at once: rotation 0,1,2,3 then 0 again.
        rst = 1; req = '0; ddr_ack = 0;
        tick();
        rst = 0; req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            int n;
            n = 0;
            while (!ddr_req && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("rot%0d_wait", j), n < 20, 1'b1);
            check($sformatf("rot%0d_idx", j), grant_idx, order[j]);
            repeat (3) tick();
            ddr_ack = 1;
            tick();
            check($sformatf("rot%0d_ack", j), ack, 4'b0001 << order[j]);
            req[order[j]] = 1'b0;
            if (j == 3) req[0] = 1'b1;
            tick();
            check($sformatf("rot%0d_hold", j), ack, 4'b0001 << order[j]);
            ddr_ack = 0;
            tick();
            check($sformatf("rot%0d_close", j), {ack, grant_valid, busy}, 6'b0);
        end

`ifdef DDR3_ARB_TIMEOUT_EN
        rst = 1; req = '0; ddr_ack = 0;
        tick();
        rst = 0; req = 4'b0100;
        tick();
        check("to_grant", ddr_req, 1'b1);
        repeat (16) tick();
        check("to_hold", ddr_req, 1'b1);
        tick();
        check("to_drop", {ddr_req, ack, grant_valid, err}, {1'b0, 4'b0000, 1'b0, 1'b1});
        req = '0;
        repeat (3) tick();
        check("to_sticky", {ack, err}, {4'b0000, 1'b1});
        err_clr = 1;
        tick();
        err_clr = 0;
        check("to_clr", err, 1'b0);
`endif

        // Randomized traffic against the transaction model.
        rst = 1; req = '0; ddr_ack = 0;
        tick();
        m_reset();
        rst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] eak;
            logic         edr;
            eak = m_ack();
            edr = (m_owner >= 0) && !m_acked;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (eak[i] && $urandom_range(1, 0) == 1) req[i] = 1'b0;
                    else if (m_owner == i && !m_acked && $urandom_range(15, 0) == 0) req[i] = 1'b0;
                end else if (!eak[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                end
                addr[28*i +: 28] = 28'($urandom);
            end
            optype = N'($urandom);
            if (!ddr_ack) begin
                if ((edr && $urandom_range(2, 0) == 0) || (m_owner < 0 && $urandom_range(31, 0) == 0))
                    ddr_ack = 1'b1;
            end else if (!edr && $urandom_range(1, 0) == 1) begin
                ddr_ack = 1'b0;
            end
            rst = ($urandom_range(299, 0) == 0);
            m_step(rst, req, optype, addr, ddr_ack);
            tick();
            check($sformatf("rand%0d", cyc), pack_dut(), m_pack());
            check($sformatf("rand%0d_onehot", cyc), $onehot0(ack), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
